// File: rtl/psum_requant.sv
// psum_requant: requantizes 32-bit signed accumulated partial sums into 8-bit
// signed activations for the next layer. Each sample carries its own unsigned
// fixed-point scale, a rounding right-shift amount and a ReLU enable. The result
// saturates to the signed output range, and clipped outputs are counted.
// Two-stage elastic pipeline with valid/ready on both sides:
//   S1 captures the sample and the scale product.
//   S2 rounds, shifts, applies ReLU and clamps into the output register.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid/in_ready    input handshake for psum_in, scale, shift, relu_en
//   psum_in              signed accumulated partial sum (ACCWIDTH)
//   scale                unsigned multiplier (MULTWIDTH)
//   shift                right-shift amount (SHIFTWIDTH)
//   relu_en              1: negative results become 0
//   out_valid/out_ready  output handshake for act_out
//   act_out              signed saturated activation (WIDTH)
//   sat_count            saturating count of transferred outputs that were clipped
module psum_requant #(
   parameter int unsigned ACCWIDTH   = 32,
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned MULTWIDTH  = 16,
   parameter int unsigned SHIFTWIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ACCWIDTH-1:0]   psum_in,
   input  logic [MULTWIDTH-1:0]  scale,
   input  logic [SHIFTWIDTH-1:0] shift,
   input  logic                  relu_en,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      act_out,
   output logic [15:0]           sat_count
);

   // Product width: signed psum times zero-extended (signed) scale.
   localparam int unsigned PW = ACCWIDTH + MULTWIDTH + 1;
   // One extra bit so the rounding addend can never overflow.
   localparam int unsigned RW = PW + 1;
   localparam int unsigned CW = 16;

   localparam logic signed [RW-1:0] ACT_MAX = RW'((2 ** (WIDTH - 1)) - 1);
   localparam logic signed [RW-1:0] ACT_MIN = -RW'(2 ** (WIDTH - 1));

   // S1 payload: product plus the per-sample controls that travel with it.
   typedef struct packed {
      logic [PW-1:0]         prod;
      logic [SHIFTWIDTH-1:0] shift;
      logic                  relu;
   } s1_t;

   // Pipeline state
   logic          s1_valid_q, s1_valid_d;
   s1_t           s1_q, s1_d;
   logic          out_valid_q, out_valid_d;
   logic [WIDTH-1:0] act_q, act_d;
   logic          sat_q, sat_d;
   logic [CW-1:0] sat_count_q, sat_count_d;

   // Datapath intermediates
   logic signed [PW-1:0] a_ext_c;
   logic signed [PW-1:0] b_ext_c;
   logic signed [PW-1:0] prod_c;
   logic signed [RW-1:0] ext_c;
   logic signed [RW-1:0] rnd_c;
   logic signed [RW-1:0] sum_c;
   logic signed [RW-1:0] r_c;
   logic                 s2_adv_c;
   logic                 s1_adv_c;

   // Handshake: each stage advances when its downstream slot frees this cycle.
   always_comb begin
      s2_adv_c = !out_valid_q || out_ready;
      s1_adv_c = !s1_valid_q || s2_adv_c;
   end

   // S1 arithmetic: signed psum times zero-extended scale.
   always_comb begin
      a_ext_c = PW'($signed(psum_in));
      b_ext_c = PW'({1'b0, scale});
      prod_c  = a_ext_c * b_ext_c;
   end

   // S2 arithmetic: rounding right shift (half toward +inf), evaluated one bit wider.
   always_comb begin
      ext_c = RW'($signed(s1_q.prod));
      rnd_c = RW'(1) << (s1_q.shift - SHIFTWIDTH'(1));
      sum_c = ext_c + rnd_c;
      if (s1_q.shift == '0) begin
         r_c = ext_c;
      end else begin
         r_c = sum_c >>> s1_q.shift;
      end
   end

   // Next-state logic for both stages and the saturation counter.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_d        = s1_q;
      out_valid_d = out_valid_q;
      act_d       = act_q;
      sat_d       = sat_q;
      sat_count_d = sat_count_q;

      if (s1_adv_c) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_d.prod  = prod_c;
            s1_d.shift = shift;
            s1_d.relu  = relu_en;
         end
      end

      if (s2_adv_c) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            // ReLU zeroing takes priority and is not a clip event.
            if (s1_q.relu && r_c < 0) begin
               act_d = '0;
               sat_d = 1'b0;
            end else if (r_c > ACT_MAX) begin
               act_d = ACT_MAX[WIDTH-1:0];
               sat_d = 1'b1;
            end else if (r_c < ACT_MIN) begin
               act_d = ACT_MIN[WIDTH-1:0];
               sat_d = 1'b1;
            end else begin
               act_d = r_c[WIDTH-1:0];
               sat_d = 1'b0;
            end
         end
      end

      // Count clipped results only when they actually leave the block.
      if (out_valid_q && out_ready && sat_q && (sat_count_q != '1)) begin
         sat_count_d = sat_count_q + CW'(1);
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_q        <= '0;
         out_valid_q <= 1'b0;
         act_q       <= '0;
         sat_q       <= 1'b0;
         sat_count_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_q        <= s1_d;
         out_valid_q <= out_valid_d;
         act_q       <= act_d;
         sat_q       <= sat_d;
         sat_count_q <= sat_count_d;
      end
   end

   assign in_ready  = s1_adv_c;
   assign out_valid = out_valid_q;
   assign act_out   = act_q;
   assign sat_count = sat_count_q;

endmodule

// File: tb/tb_psum_requant.sv
// Self-checking bench for psum_requant: directed steps drive samples, a reference
// model pushes expected results into a scoreboard, and an output monitor pops and
// compares each transferred activation.
module tb_psum_requant;

   typedef struct packed {
      logic [7:0] act;
      logic       sat;
   } sb_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] psum_in;
   logic [15:0] scale;
   logic [4:0]  shift;
   logic        relu_en;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  act_out;
   logic [15:0] sat_count;

   int   total;
   int   bad;
   int   exp_sat;
   int   cyc;
   sb_t  sb[$];
   int   pop_times[$];

   psum_requant dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .psum_in   (psum_in),
      .scale     (scale),
      .shift     (shift),
      .relu_en   (relu_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .act_out   (act_out),
      .sat_count (sat_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: full-precision product, rounding shift, ReLU, clamp to int8.
   function automatic sb_t model(input logic [31:0] p_in, input logic [15:0] sc,
                                 input logic [4:0] sh, input logic relu);
      longint p;
      longint r;
      sb_t    e;
      p = longint'($signed(p_in)) * longint'({48'd0, sc});
      if (sh == 5'd0) r = p;
      else r = (p + (longint'(1) <<< (sh - 5'd1))) >>> sh;
      e.sat = 1'b0;
      if (relu && r < 0) e.act = 8'h00;
      else if (r > 127) begin e.act = 8'h7F; e.sat = 1'b1; end
      else if (r < -128) begin e.act = 8'h80; e.sat = 1'b1; end
      else e.act = r[7:0];
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Output monitor: every transfer must match the oldest expected result.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         total++;
         assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_output observed=%0h expected=none", act_out);
         end
         if (sb.size() != 0) begin
            sb_t e;
            e = sb.pop_front();
            total++;
            assert (act_out === e.act) else begin
               bad++;
               $error("FAIL act_out observed=%0h expected=%0h", act_out, e.act);
            end
            if (e.sat) exp_sat++;
            pop_times.push_back(cyc);
         end
      end
   end

   // Presents one sample and holds it until accepted (bounded wait).
   task automatic send(input logic [31:0] p_in, input logic [15:0] sc,
                       input logic [4:0] sh, input logic relu);
      bit ok;
      ok       = 1'b0;
      psum_in  = p_in;
      scale    = sc;
      shift    = sh;
      relu_en  = relu;
      in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      total++;
      assert (ok) else begin
         bad++;
         $error("FAIL accept_timeout observed=0 expected=1");
      end
      if (ok) begin
         @(posedge clk);
         sb.push_back(model(p_in, sc, sh, relu));
         #1;
      end
      in_valid = 1'b0;
   endtask

   // Waits for the scoreboard to empty, then lets the counter settle.
   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      exp_sat   = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      psum_in   = '0;
      scale     = '0;
      shift     = '0;
      relu_en   = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_act_out",   32'(act_out),   32'd0);
      chk("rst_sat_count", 32'(sat_count), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      @(posedge clk);
      #1;

      // Basic scaling and latency: 300*3 = 900, (900+4)>>3 = 113
      send(32'd300, 16'd3, 5'd3, 1'b0);
      @(negedge clk);
      chk("lat_early_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("lat_act",   32'(act_out),   32'h71);
      drain();

      // Negative rounding and ReLU
      send(32'(-5), 16'd1, 5'd1, 1'b0);
      send(32'(-5), 16'd1, 5'd1, 1'b1);
      drain();
      chk("relu_sat_count", 32'(sat_count), 32'd0);

      // Positive and negative saturation
      send(32'h7FFF_FFFF, 16'hFFFF, 5'd0, 1'b0);
      send(32'(-1000000), 16'd1, 5'd0, 1'b0);
      drain();
      chk("sat_count_two",   32'(sat_count), 32'd2);
      chk("sat_count_model", 32'(sat_count), 32'(exp_sat));

      // scale 0 never saturates
      send(32'h8000_0000, 16'd0, 5'd0, 1'b0);
      drain();
      chk("scale0_sat_count", 32'(sat_count), 32'd2);

      // Backpressure: two buffered, third refused, output held
      out_ready = 1'b0;
      send(32'd1, 16'd1, 5'd0, 1'b0);
      send(32'd2, 16'd1, 5'd0, 1'b0);
      psum_in  = 32'd3;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_in_ready",  32'(in_ready),  32'd0);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_act_hold",  32'(act_out),   32'd1);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(32'd3, 16'd1, 5'd0, 1'b0);
      drain();

      // Full-throughput stream
      pop_times.delete();
      for (int i = 0; i < 16; i++) begin
         send(32'(i * 37 - 300), 16'(i + 1), 5'(i % 8), 1'(i % 2));
      end
      drain();
      chk("stream_count", 32'(pop_times.size()), 32'd16);
      if (pop_times.size() == 16) begin
         chk("stream_span", 32'(pop_times[15] - pop_times[0]), 32'd15);
      end

      // Reset with two samples in flight
      out_ready = 1'b0;
      send(32'd5000, 16'd1, 5'd0, 1'b0);
      send(32'(-5000), 16'd1, 5'd0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      exp_sat = 0;
      @(negedge clk);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_sat_count", 32'(sat_count), 32'd0);
      chk("midrst_in_ready",  32'(in_ready),  32'd1);
      @(posedge clk);
      #1 out_ready = 1'b1;
      repeat (8) @(negedge clk);
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      send(32'd10, 16'd2, 5'd1, 1'b0);
      drain();
      chk("post_rst_sat_count", 32'(sat_count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
